// File: rtl/pool_frame_buffer.sv
// rtl/pool_frame_buffer.sv - captures one pooled feature map and replays it in raster order
// Fill from a free-running sof/valid stream, drain over valid/ready with no bubbles.
module pool_frame_buffer #(
   parameter int data_width = 32,
   parameter int frame_x    = 2,
   parameter int frame_y    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_sof,
   input  logic                  input_valid,
   input  logic [data_width-1:0] d_in,
   input  logic                  o_ready,
   output logic                  output_valid,
   output logic [data_width-1:0] d_out,
   output logic                  o_sof,
   output logic                  o_eof,
   output logic                  busy,
   input  logic                  clr_err,
   output logic                  overflow,
   output logic                  sync_err
);

   localparam int depth = frame_x * frame_y;
   localparam int aw    = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [aw-1:0] last_addr = aw'(depth - 1);
   localparam logic [aw-1:0] restart_ptr = (depth > 1) ? aw'(1) : '0;

   typedef enum logic [1:0] {
      st_idle,
      st_fill,
      st_drain
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [data_width-1:0] mem [depth];
   logic [aw-1:0]         wr_ptr;
   logic [aw-1:0]         wr_ptr_nx;
   logic [aw-1:0]         wr_addr;
   logic                  wr_en;
   logic [aw-1:0]         rd_ptr;
   logic [aw-1:0]         out_idx;
   logic                  set_sync;
   logic                  set_ovf;
   logic                  load;
   logic                  last_hs;
   logic                  handshake;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= st_idle;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      wr_en     = 1'b0;
      wr_addr   = wr_ptr;
      wr_ptr_nx = wr_ptr;
      set_sync  = 1'b0;
      set_ovf   = 1'b0;
      handshake = output_valid && o_ready;
      last_hs   = (state == st_drain) && handshake && (out_idx == last_addr);
      // First word after entering DRAIN, or the prefetched next word on each handshake
      load      = (state == st_drain) &&
                  (!output_valid || (handshake && (out_idx != last_addr)));
      case (state)
         st_idle: begin
            if (input_valid) begin
               if (i_sof) begin
                  wr_en     = 1'b1;
                  wr_addr   = '0;
                  wr_ptr_nx = restart_ptr;
                  state_nx  = (depth == 1) ? st_drain : st_fill;
               end else begin
                  set_sync = 1'b1;
               end
            end
         end
         st_fill: begin
            if (input_valid) begin
               wr_en = 1'b1;
               if (i_sof) begin
                  wr_addr   = '0;
                  wr_ptr_nx = restart_ptr;
                  set_sync  = 1'b1;
                  state_nx  = (depth == 1) ? st_drain : st_fill;
               end else if (wr_ptr == last_addr) begin
                  wr_ptr_nx = '0;
                  state_nx  = st_drain;
               end else begin
                  wr_ptr_nx = wr_ptr + 1'b1;
               end
            end
         end
         st_drain: begin
            if (last_hs) begin
               state_nx = st_idle;
            end
            // A new frame may start exactly on the final handshake without loss
            if (input_valid) begin
               if (i_sof && last_hs) begin
                  wr_en     = 1'b1;
                  wr_addr   = '0;
                  wr_ptr_nx = restart_ptr;
                  state_nx  = (depth == 1) ? st_drain : st_fill;
               end else begin
                  set_ovf = 1'b1;
               end
            end
         end
         default: begin
            state_nx = st_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= d_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         out_idx      <= '0;
         output_valid <= 1'b0;
         d_out        <= '0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nx;
         if (load) begin
            d_out        <= mem[rd_ptr];
            out_idx      <= rd_ptr;
            o_sof        <= (rd_ptr == '0);
            o_eof        <= (rd_ptr == last_addr);
            output_valid <= 1'b1;
            rd_ptr       <= (rd_ptr == last_addr) ? '0 : rd_ptr + 1'b1;
         end else if (last_hs) begin
            output_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            rd_ptr       <= '0;
         end
      end
   end

   // Setting events take priority over a same-cycle clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         if (set_ovf) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (set_sync) begin
            sync_err <= 1'b1;
         end else if (clr_err) begin
            sync_err <= 1'b0;
         end
      end
   end

   assign busy = (state != st_idle);

endmodule
